// File: rtl/hazard_stall_controller_pkg.sv
// Shared definitions for the hazard/stall sequencer: FSM encodings, the x0
// register index and the packed bundle of pipeline control outputs.
package hazard_stall_controller_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MC_BUSY  = 2'd1,
    MEM_WAIT = 2'd2
  } state_t;

  localparam int X0_IDX = 0;

  typedef struct packed {
    logic pc_write;
    logic ifid_write;
    logic ifid_flush;
    logic idex_bubble;
    logic ex_hold;
    logic mem_bubble;
    logic mem_hold;
    logic wb_bubble;
  } ctrl_t;

  localparam ctrl_t CTRL_OFF   = '{default: 1'b0};
  localparam ctrl_t CTRL_RUN   = '{pc_write: 1'b1, ifid_write: 1'b1, default: 1'b0};
  localparam ctrl_t CTRL_FLUSH = '{pc_write: 1'b1, ifid_write: 1'b1, ifid_flush: 1'b1, default: 1'b0};
  localparam ctrl_t CTRL_LU    = '{idex_bubble: 1'b1, default: 1'b0};
  localparam ctrl_t CTRL_MC    = '{ex_hold: 1'b1, mem_bubble: 1'b1, default: 1'b0};
  localparam ctrl_t CTRL_MEM   = '{ex_hold: 1'b1, mem_hold: 1'b1, wb_bubble: 1'b1, default: 1'b0};

endpackage

// File: rtl/hazard_stall_controller_stall_monitor.sv
// Stall statistics: saturating total stall count, consecutive-stall counter
// and a sticky timeout flag raised when the pipeline looks stuck.
module hazard_stall_controller_stall_monitor #(
  parameter int CNT_W       = 32,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             stall,
  output logic [CNT_W-1:0] stall_cycles,
  output logic             timeout
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  logic [TW-1:0] consec;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stall_cycles <= '0;
      consec       <= '0;
      timeout      <= 1'b0;
    end else if (stall) begin
      if (stall_cycles != '1) stall_cycles <= stall_cycles + CNT_W'(1);
      if (consec != TW'(TIMEOUT_CYC)) consec <= consec + TW'(1);
      // This edge completes the TIMEOUT_CYC-th consecutive stall cycle.
      if (consec == TW'(TIMEOUT_CYC - 1)) timeout <= 1'b1;
    end else begin
      consec <= '0;
    end
  end

endmodule

// File: rtl/hazard_stall_controller.sv
// Pipeline sequencer: resolves load-use, multi-cycle EX and MEM-busy hazards,
// drives stage enables/bubbles/holds and branch flush, and monitors stalls.
module hazard_stall_controller
  import hazard_stall_controller_pkg::*;
#(
  parameter int REG_W       = 5,
  parameter int CNT_W       = 32,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [REG_W-1:0] IDRs1_i,
  input  logic [REG_W-1:0] IDRs2_i,
  input  logic             IDUsesRs2_i,
  input  logic             EXMemRead_i,
  input  logic [REG_W-1:0] EXRd_i,
  input  logic             BranchTaken_i,
  input  logic             MCStart_i,
  input  logic             MCDone_i,
  input  logic             MemBusy_i,
  output logic             PCWrite_o,
  output logic             IFIDWrite_o,
  output logic             IFIDFlush_o,
  output logic             IDEXBubble_o,
  output logic             EXHold_o,
  output logic             MEMBubble_o,
  output logic             MEMHold_o,
  output logic             WBBubble_o,
  output logic [CNT_W-1:0] StallCycles_o,
  output logic             Timeout_o,
  output logic [1:0]       dbg_state
);

  state_t state, state_nx, ret, ret_nx, eff_state;
  logic   pend, pend_nx;
  logic   lu_hz, in_mc;
  ctrl_t  ctrl;

  assign lu_hz = EXMemRead_i && (EXRd_i != REG_W'(X0_IDX)) &&
                 ((EXRd_i == IDRs1_i) || (IDUsesRs2_i && (EXRd_i == IDRs2_i)));

  // While parked in MEM_WAIT the state to resume decides the non-busy behaviour.
  assign eff_state = (state == MEM_WAIT) ? ret : state;
  assign in_mc     = (eff_state == MC_BUSY);

  always_comb begin
    ctrl     = CTRL_RUN;
    state_nx = state;
    ret_nx   = ret;
    pend_nx  = pend;
    if (rst_i) begin
      ctrl = CTRL_OFF;
    end else if (MemBusy_i) begin
      ctrl = CTRL_MEM;
      if (state != MEM_WAIT) begin
        state_nx = MEM_WAIT;
        ret_nx   = state;
      end
      if (in_mc && MCDone_i) pend_nx = 1'b1;
    end else if (in_mc) begin
      if (pend || MCDone_i) begin
        state_nx = RUN;
        pend_nx  = 1'b0;
      end else begin
        ctrl     = CTRL_MC;
        state_nx = MC_BUSY;
      end
    end else begin
      state_nx = RUN;
      pend_nx  = 1'b0;
      if (MCStart_i && !MCDone_i) begin
        ctrl     = CTRL_MC;
        state_nx = MC_BUSY;
      end else if (lu_hz) begin
        ctrl = CTRL_LU;
      end else if (BranchTaken_i) begin
        ctrl = CTRL_FLUSH;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= RUN;
      ret   <= RUN;
      pend  <= 1'b0;
    end else begin
      state <= state_nx;
      ret   <= ret_nx;
      pend  <= pend_nx;
    end
  end

  assign PCWrite_o    = ctrl.pc_write;
  assign IFIDWrite_o  = ctrl.ifid_write;
  assign IFIDFlush_o  = ctrl.ifid_flush;
  assign IDEXBubble_o = ctrl.idex_bubble;
  assign EXHold_o     = ctrl.ex_hold;
  assign MEMBubble_o  = ctrl.mem_bubble;
  assign MEMHold_o    = ctrl.mem_hold;
  assign WBBubble_o   = ctrl.wb_bubble;
  assign dbg_state    = state;

  hazard_stall_controller_stall_monitor #(
    .CNT_W       (CNT_W),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_stall_monitor (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .stall        (~ctrl.pc_write),
    .stall_cycles (StallCycles_o),
    .timeout      (Timeout_o)
  );

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Directed bench for hazard_stall_controller: inputs change on the falling
// edge, combinational outputs are checked before the next rising edge.
module tb_hazard_stall_controller;

  // Control bundle order: PCWrite, IFIDWrite, IFIDFlush, IDEXBubble,
  // EXHold, MEMBubble, MEMHold, WBBubble.
  localparam logic [7:0] E_ZERO  = 8'b0000_0000;
  localparam logic [7:0] E_NORM  = 8'b1100_0000;
  localparam logic [7:0] E_FLUSH = 8'b1110_0000;
  localparam logic [7:0] E_LU    = 8'b0001_0000;
  localparam logic [7:0] E_MC    = 8'b0000_1100;
  localparam logic [7:0] E_MEM   = 8'b0000_1011;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  id_rs1, id_rs2, ex_rd;
  logic        id_uses_rs2, ex_mem_read, branch_taken, mc_start, mc_done, mem_busy;
  logic        pc_write, ifid_write, ifid_flush, idex_bubble;
  logic        ex_hold, mem_bubble, mem_hold, wb_bubble, timeout;
  logic [31:0] stall_cycles;
  logic [1:0]  dbg_state;
  logic [7:0]  outs;

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  assign outs = {pc_write, ifid_write, ifid_flush, idex_bubble,
                 ex_hold, mem_bubble, mem_hold, wb_bubble};

  hazard_stall_controller dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .IDRs1_i       (id_rs1),
    .IDRs2_i       (id_rs2),
    .IDUsesRs2_i   (id_uses_rs2),
    .EXMemRead_i   (ex_mem_read),
    .EXRd_i        (ex_rd),
    .BranchTaken_i (branch_taken),
    .MCStart_i     (mc_start),
    .MCDone_i      (mc_done),
    .MemBusy_i     (mem_busy),
    .PCWrite_o     (pc_write),
    .IFIDWrite_o   (ifid_write),
    .IFIDFlush_o   (ifid_flush),
    .IDEXBubble_o  (idex_bubble),
    .EXHold_o      (ex_hold),
    .MEMBubble_o   (mem_bubble),
    .MEMHold_o     (mem_hold),
    .WBBubble_o    (wb_bubble),
    .StallCycles_o (stall_cycles),
    .Timeout_o     (timeout),
    .dbg_state     (dbg_state)
  );

  task automatic chk_ctrl(input string tag, input logic [7:0] exp);
    vectors++;
    assert (outs === exp) else begin
      errors++;
      $error("FAIL %s ctrl observed=%b expected=%b", tag, outs, exp);
    end
  endtask

  task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    id_rs1 = '0; id_rs2 = '0; ex_rd = '0; id_uses_rs2 = 1'b0; ex_mem_read = 1'b0;
    branch_taken = 1'b0; mc_start = 1'b0; mc_done = 1'b0; mem_busy = 1'b0;
  endtask

  task automatic next_cycle();
    @(negedge clk);
    clear_inputs();
  endtask

  task automatic pulse_reset();
    #1 rst = 1'b1;
    #1 rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();
    @(negedge clk);
    @(negedge clk);
    #1;
    chk_ctrl("reset_outputs", E_ZERO);
    chk_val("reset_stall_cycles", stall_cycles, 32'd0);
    chk_val("reset_timeout", 32'(timeout), 32'd0);
    chk_val("reset_state", 32'(dbg_state), 32'd0);
    rst = 1'b0;

    // Idle pipeline
    next_cycle(); #1 chk_ctrl("idle", E_NORM);

    // Load-use on rs1, then the load advances
    next_cycle(); ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5;
    #1 chk_ctrl("lu_rs1", E_LU);
    next_cycle(); #1 chk_ctrl("lu_rs1_cleared", E_NORM);

    // Load into x0 never stalls
    next_cycle(); ex_mem_read = 1'b1; ex_rd = 5'd0; id_rs1 = 5'd0;
    #1 chk_ctrl("lu_x0", E_NORM);

    // rs2 match only matters when rs2 is read
    next_cycle(); ex_mem_read = 1'b1; ex_rd = 5'd7; id_rs1 = 5'd1; id_rs2 = 5'd7;
    #1 chk_ctrl("lu_rs2_unused", E_NORM);
    id_uses_rs2 = 1'b1;
    #1 chk_ctrl("lu_rs2_used", E_LU);

    // Load-use suppresses a same-cycle taken branch
    next_cycle(); ex_mem_read = 1'b1; ex_rd = 5'd7; id_rs2 = 5'd7; id_uses_rs2 = 1'b1;
    branch_taken = 1'b1;
    #1 chk_ctrl("lu_with_branch", E_LU);
    next_cycle(); branch_taken = 1'b1;
    #1 chk_ctrl("branch_flush", E_FLUSH);
    next_cycle(); #1 chk_val("stall_cycles_lu", stall_cycles, 32'd3);

    pulse_reset();
    #1 chk_val("stall_cycles_after_reset", stall_cycles, 32'd0);

    // Multi-cycle op: start, three busy cycles, done on the fourth
    next_cycle(); mc_start = 1'b1;
    #1 chk_ctrl("mc_start", E_MC);
    next_cycle(); #1 chk_ctrl("mc_busy1", E_MC);
    chk_val("mc_state", 32'(dbg_state), 32'd1);
    next_cycle(); #1 chk_ctrl("mc_busy2", E_MC);
    next_cycle(); #1 chk_ctrl("mc_busy3", E_MC);
    next_cycle(); mc_done = 1'b1;
    #1 chk_ctrl("mc_done_free", E_NORM);
    next_cycle(); #1 chk_val("mc_stall_cycles", stall_cycles, 32'd4);
    chk_val("mc_back_run", 32'(dbg_state), 32'd0);

    // Start with done in the same cycle: no stall
    mc_start = 1'b1; mc_done = 1'b1;
    #1 chk_ctrl("mc_start_done", E_NORM);

    // MEM busy during MC_BUSY, done arrives while parked
    next_cycle(); mc_start = 1'b1;
    #1 chk_ctrl("mc2_start", E_MC);
    next_cycle(); mem_busy = 1'b1;
    #1 chk_ctrl("mw_busy1", E_MEM);
    next_cycle(); mem_busy = 1'b1; mc_done = 1'b1;
    #1 chk_ctrl("mw_busy2_done", E_MEM);
    chk_val("mw_state", 32'(dbg_state), 32'd2);
    next_cycle(); mem_busy = 1'b1;
    #1 chk_ctrl("mw_busy3", E_MEM);
    next_cycle(); #1 chk_ctrl("mw_exit_pend", E_NORM);
    next_cycle(); #1 chk_val("mw_exit_state", 32'(dbg_state), 32'd0);
    chk_val("mw_stall_cycles", stall_cycles, 32'd8);
    chk_ctrl("mw_no_restall", E_NORM);

    // Timeout after 64 consecutive MEM-busy cycles
    repeat (63) begin
      mem_busy = 1'b1;
      @(negedge clk);
    end
    chk_val("timeout_63", 32'(timeout), 32'd0);
    mem_busy = 1'b1;
    @(negedge clk);
    chk_val("timeout_64", 32'(timeout), 32'd1);
    mem_busy = 1'b0;
    #1 chk_ctrl("timeout_release", E_NORM);
    next_cycle(); #1 chk_val("timeout_sticky", 32'(timeout), 32'd1);
    chk_val("timeout_stall_cycles", stall_cycles, 32'd72);
    rst = 1'b1;
    #1 chk_val("timeout_rst_clear", 32'(timeout), 32'd0);
    rst = 1'b0;

    // Asynchronous reset in the middle of MC_BUSY
    next_cycle(); mc_start = 1'b1;
    next_cycle(); #1 chk_ctrl("arst_mc_busy", E_MC);
    #1 rst = 1'b1;
    #1 chk_ctrl("arst_outputs", E_ZERO);
    chk_val("arst_state", 32'(dbg_state), 32'd0);
    chk_val("arst_stall_cycles", stall_cycles, 32'd0);
    rst = 1'b0;
    #1 chk_ctrl("arst_release", E_NORM);
    next_cycle(); #1 chk_ctrl("arst_run", E_NORM);
    chk_val("arst_run_state", 32'(dbg_state), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
